// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte engine and its divider.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        TRAIL
    } state_e;

    localparam logic       MOSI_IDLE = 1'b1;
    localparam logic [7:0] RXD_RESET = 8'h00;
    localparam int         BITS      = 8;

endpackage

// File: rtl/spi_byte_engine_if.sv
// Decoder-side load/result bus plus the SPI pins of the byte engine.
interface spi_byte_engine_if;
    import spi_pkg::*;

    logic            LOAD;
    logic [BITS-1:0] TXD;
    logic            CPOL;
    logic            MISO;
    logic            SCK;
    logic            MOSI;
    logic [BITS-1:0] RXD;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    modport slave (
        input  LOAD, TXD, CPOL, MISO,
        output SCK, MOSI, RXD, BUSY, DONE, ERR
    );

    modport master (
        output LOAD, TXD, CPOL, MISO,
        input  SCK, MOSI, RXD, BUSY, DONE, ERR
    );

endinterface

// File: rtl/spi_tick_gen.sv
// SCK half-period divider: tick every HALF cycles while run is high.
module spi_tick_gen #(
    parameter int HALF = 2,
    parameter int CW   = 8
) (
    input  logic CLK,
    input  logic nRESET,
    input  logic run,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] div_q;

    // NOTE: tick is combinational from the registered count so the FSM can act on it in the same cycle the count wraps.
    assign tick = run && (div_q == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees the pre-edge value.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            div_q <= '0;
        end else if (!run || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// CPHA=0 SPI byte shifter: one LOAD shifts TXD out MSB first while collecting MISO into RXD.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int HALF = 2,
    parameter int CW   = 8
) (
    input  logic               CLK,
    input  logic               nRESET,
    spi_byte_engine_if.slave   bus
);

    state_e          state_q;
    logic [BITS-1:0] tx_q;
    logic [BITS-1:0] rx_q;
    logic [BITS-1:0] rxd_q;
    logic [2:0]      bitcnt_q;
    logic            pol_q;
    logic            sck_q;
    logic            mosi_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic            run;
    logic            tick;

    assign run = (state_q != IDLE);

    spi_tick_gen #(
        .HALF (HALF),
        .CW   (CW)
    ) u_tick_gen (
        .CLK    (CLK),
        .nRESET (nRESET),
        .run    (run),
        .tick   (tick)
    );

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            tx_q     <= '0;
            rx_q     <= '0;
            rxd_q    <= RXD_RESET;
            bitcnt_q <= '0;
            pol_q    <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= MOSI_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: done_q defaults low every cycle so a single set below yields a one-cycle pulse.
            done_q <= 1'b0;

            // A LOAD while a byte is in flight is dropped and only flagged.
            if (bus.LOAD && run) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    sck_q <= bus.CPOL;
                    if (bus.LOAD) begin
                        tx_q     <= bus.TXD;
                        mosi_q   <= bus.TXD[BITS-1];
                        pol_q    <= bus.CPOL;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        state_q  <= LEAD;
                    end
                end

                LEAD: begin
                    if (tick) begin
                        sck_q   <= ~pol_q;
                        rx_q    <= {rx_q[BITS-2:0], bus.MISO};
                        state_q <= TRAIL;
                    end
                end

                TRAIL: begin
                    if (tick) begin
                        sck_q <= pol_q;
                        if (bitcnt_q != 3'd7) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            tx_q     <= {tx_q[BITS-2:0], 1'b0};
                            mosi_q   <= tx_q[BITS-2];
                            state_q  <= LEAD;
                        end else begin
                            mosi_q  <= MOSI_IDLE;
                            rxd_q   <= rx_q;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.SCK  = sck_q;
    assign bus.MOSI = mosi_q;
    assign bus.RXD  = rxd_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: loopback, constant MISO, CPOL=1, overrun, back-to-back, reset abort.
module tb_spi_byte_engine;

    localparam int HALF = 2;
    localparam int LAST = 16 * HALF;

    logic clk;
    logic nreset;
    logic loop_en;
    logic miso_val;

    int checks;
    int failures;
    int cyc;
    int done_cnt;
    int prev_done;
    int last_done;

    logic [7:0] rxd_exp;
    logic       err_exp;

    spi_byte_engine_if sif ();

    assign sif.MISO = loop_en ? sif.MOSI : miso_val;

    spi_byte_engine #(
        .HALF (HALF),
        .CW   (8)
    ) dut (
        .CLK    (clk),
        .nRESET (nreset),
        .bus    (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sif.DONE === 1'b1) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        sif.LOAD = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Entered and left at a negedge; the return point is the DONE cycle.
    task automatic xfer(input string tag, input logic [7:0] tx, input logic cpol,
                        input logic [7:0] pat, input logic lp, input int ovr_k,
                        input logic [7:0] exp_rx);
        logic sck_e;
        logic mosi_e;
        int   idx;
        loop_en  = lp;
        sif.LOAD = 1'b1;
        sif.TXD  = tx;
        sif.CPOL = cpol;
        @(posedge clk);
        @(negedge clk);
        sif.LOAD = 1'b0;
        sif.TXD  = ~tx;
        err_exp  = 1'b0;
        check({tag, "_c0_busy"}, 32'(sif.BUSY), 32'd1);
        check({tag, "_c0_mosi"}, 32'(sif.MOSI), 32'(tx[7]));
        check({tag, "_c0_sck"},  32'(sif.SCK),  32'(cpol));
        check({tag, "_c0_err"},  32'(sif.ERR),  32'd0);
        check({tag, "_c0_done"}, 32'(sif.DONE), 32'd0);
        for (int k = 1; k <= LAST; k++) begin
            idx      = (k - 1) / (2 * HALF);
            miso_val = pat[7 - idx];
            sif.LOAD = (k == ovr_k);
            if (k == ovr_k) sif.TXD = 8'h00;
            sif.CPOL = (k >= 3 && k < LAST) ? ~cpol : cpol;
            @(posedge clk);
            if (k == ovr_k) err_exp = 1'b1;
            @(negedge clk);
            sck_e  = cpol ^ ((k / HALF) % 2 == 1);
            mosi_e = (k < LAST) ? tx[7 - (k / (2 * HALF))] : 1'b1;
            check($sformatf("%s_k%0d_sck", tag, k),  32'(sif.SCK),  32'(sck_e));
            check($sformatf("%s_k%0d_mosi", tag, k), 32'(sif.MOSI), 32'(mosi_e));
            check($sformatf("%s_k%0d_busy", tag, k), 32'(sif.BUSY), 32'(k < LAST));
            check($sformatf("%s_k%0d_done", tag, k), 32'(sif.DONE), 32'(k == LAST));
            check($sformatf("%s_k%0d_err", tag, k),  32'(sif.ERR),  32'(err_exp));
            check($sformatf("%s_k%0d_rxd", tag, k),  32'(sif.RXD),
                  32'((k < LAST) ? rxd_exp : exp_rx));
        end
        sif.LOAD = 1'b0;
        rxd_exp  = exp_rx;
    endtask

    initial begin
        int dc;
        checks    = 0;
        failures  = 0;
        done_cnt  = 0;
        prev_done = 0;
        last_done = 0;
        loop_en   = 1'b0;
        miso_val  = 1'b0;
        rxd_exp   = 8'h00;
        err_exp   = 1'b0;
        sif.LOAD  = 1'b0;
        sif.TXD   = 8'h00;
        sif.CPOL  = 1'b0;
        nreset    = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst_sck",  32'(sif.SCK),  32'd0);
        check("rst_mosi", 32'(sif.MOSI), 32'd1);
        check("rst_rxd",  32'(sif.RXD),  32'h00);
        check("rst_busy", 32'(sif.BUSY), 32'd0);
        check("rst_done", 32'(sif.DONE), 32'd0);
        check("rst_err",  32'(sif.ERR),  32'd0);
        nreset = 1'b1;
        idle(2);

        xfer("loop_a5", 8'hA5, 1'b0, 8'h00, 1'b1, 0, 8'hA5);
        idle(2);
        check("loop_mosi_idle", 32'(sif.MOSI), 32'd1);

        // Second transfer starts from the DONE cycle of the first.
        xfer("miso0", 8'hFF, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        xfer("miso1", 8'h00, 1'b0, 8'hFF, 1'b0, 0, 8'hFF);
        idle(1);
        // LOAD in the DONE cycle is accepted on the edge that closes it, hence the extra cycle.
        check("b2b_done_gap", 32'(last_done - prev_done), 32'(LAST + 1));

        sif.CPOL = 1'b1;
        idle(2);
        check("cpol1_idle_sck", 32'(sif.SCK), 32'd1);
        xfer("cpol1", 8'h96, 1'b1, 8'h3C, 1'b0, 0, 8'h3C);
        idle(2);
        check("cpol1_end_sck", 32'(sif.SCK), 32'd1);
        sif.CPOL = 1'b0;
        idle(2);

        xfer("ovr", 8'h5A, 1'b0, 8'h00, 1'b1, 5, 8'h5A);
        idle(2);
        check("ovr_err_sticky", 32'(sif.ERR), 32'd1);
        xfer("ovr_clr", 8'hC3, 1'b0, 8'h00, 1'b1, 0, 8'hC3);
        idle(2);

        // Abort mid-transfer.
        loop_en  = 1'b1;
        sif.LOAD = 1'b1;
        sif.TXD  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        sif.LOAD = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        dc     = done_cnt;
        nreset = 1'b0;
        #1;
        check("abort_sck",  32'(sif.SCK),  32'd0);
        check("abort_mosi", 32'(sif.MOSI), 32'd1);
        check("abort_busy", 32'(sif.BUSY), 32'd0);
        check("abort_rxd",  32'(sif.RXD),  32'h00);
        check("abort_done", 32'(sif.DONE), 32'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        idle(LAST + 8);
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_idle_busy", 32'(sif.BUSY), 32'd0);
        check("abort_rxd_hold", 32'(sif.RXD), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
